// File: rtl/sdram_wb_bridge.sv
// -----------------------------------------------------------------------------
// sdram_wb_bridge
//   Wishbone classic slave in front of the SDRAM controller's command/FIFO
//   user interface. Writes are pushed into the controller write FIFO; reads
//   open a controller read burst and pop the read FIFO. Sequential single-beat
//   cycles in the same direction share one controller burst; a direction
//   change, an address jump or a long bus-idle period closes it, followed by a
//   mandatory idle gap before the next burst request.
//
//   Optional feature macro: SDRAM_WB_TIMEOUT_EN
//     defined   : read wait is bounded by TIMEOUT_CYCLES, expiry answers the
//                 cycle with a one-cycle wbs_err_o and closes the burst
//     undefined : reads wait indefinitely, wbs_err_o tied 0
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i     Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i     byte enables, byte address
//   wbs_dat_i / wbs_dat_o    write data / read data (valid with ack)
//   wbs_ack_o, wbs_err_o     one-cycle acknowledge / error
//   wr_fifo_wr/data/mask     write FIFO push, data, byte mask (1 = masked)
//   wr_fifo_full             write FIFO full
//   rd_fifo_rd               read FIFO pop, data valid the following cycle
//   rd_fifo_data/empty       read FIFO data and empty flag
//   rd_fifo_reset            read FIFO flush pulse at the start of a read burst
//   write_en, read_en        controller burst requests, held for the burst
//   address                  burst start word address
//   sdram_ready              controller initialisation done
// -----------------------------------------------------------------------------
module sdram_wb_bridge #(
  parameter int ADDR_LSB       = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wr_fifo_wr,
  output logic [31:0] wr_fifo_data,
  output logic [3:0]  wr_fifo_mask,
  input  logic        wr_fifo_full,
  output logic        rd_fifo_rd,
  input  logic [31:0] rd_fifo_data,
  input  logic        rd_fifo_empty,
  output logic        rd_fifo_reset,
  output logic        write_en,
  output logic        read_en,
  output logic [21:0] address,
  input  logic        sdram_ready
);

  // RD_POP is the cycle in which the FIFO performs the pop requested by
  // rd_fifo_rd; its data is only valid in the cycle after that (RD_CAP).
  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_POP, RD_CAP, RD, GAP} state_t;

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES - 1);

  state_t        state, state_next;
  logic [21:0]   word, next_addr, next_addr_d, address_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d, idle_cnt, idle_cnt_d;
  logic          req, busy, open_req, same_addr, idle_expire, timeout_hit;
  logic          write_en_d, read_en_d, wr_fifo_wr_d, rd_fifo_rd_d;
  logic          rd_fifo_reset_d, ack_d;
  logic [31:0]   wr_fifo_data_d, dat_d;
  logic [3:0]    wr_fifo_mask_d;
  logic          unused_adr;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign word      = wbs_adr_i[ADDR_LSB+21:ADDR_LSB];
  assign unused_adr = ^wbs_adr_i;
  // While ack/err is on the bus the master still drives the request it is
  // about to retire, so that request must not be decoded a second time.
  assign busy      = wbs_ack_o | wbs_err_o;
  assign open_req  = req & ~busy;
  assign same_addr = (word == next_addr);
  assign idle_expire = ~wbs_cyc_i && (idle_cnt == GAP_LAST);

`ifdef SDRAM_WB_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Fires on the TIMEOUT_CYCLES-th empty cycle counted from RD_WAIT entry.
  assign timeout_hit = (state == RD_WAIT) && rd_fifo_empty && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      wbs_err_o <= 1'b0;
    end else begin
      tmo_cnt   <= (state == RD_WAIT && rd_fifo_empty && !timeout_hit) ? tmo_cnt + TW'(1) : '0;
      wbs_err_o <= timeout_hit && wbs_cyc_i;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign wbs_err_o   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (req && sdram_ready) state_next = wbs_we_i ? WR : RD_WAIT;
      WR:      if (idle_expire || (open_req && !(wbs_we_i && same_addr))) state_next = GAP;
      RD_WAIT: if (!wbs_cyc_i || timeout_hit) state_next = GAP;
               else if (!rd_fifo_empty)       state_next = RD_POP;
      RD_POP:  state_next = wbs_cyc_i ? RD_CAP : GAP;
      RD_CAP:  state_next = wbs_cyc_i ? RD : GAP;
      RD:      if (idle_expire || (open_req && (wbs_we_i || !same_addr))) state_next = GAP;
               else if (open_req)                                          state_next = RD_WAIT;
      GAP:     if (gap_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    write_en_d      = write_en;
    read_en_d       = read_en;
    address_d       = address;
    next_addr_d     = next_addr;
    wr_fifo_data_d  = wr_fifo_data;
    wr_fifo_mask_d  = wr_fifo_mask;
    dat_d           = wbs_dat_o;
    wr_fifo_wr_d    = 1'b0;
    rd_fifo_rd_d    = 1'b0;
    rd_fifo_reset_d = 1'b0;
    ack_d           = 1'b0;
    gap_cnt_d       = gap_cnt;
    idle_cnt_d      = ((state == WR || state == RD) && !wbs_cyc_i && !idle_expire)
                      ? idle_cnt + GW'(1) : '0;

    unique case (state)
      IDLE: if (state_next != IDLE) begin
        address_d   = word;
        next_addr_d = word;
        if (wbs_we_i) begin
          write_en_d = 1'b1;
        end else begin
          read_en_d       = 1'b1;
          rd_fifo_reset_d = 1'b1;
        end
      end
      WR: if (state_next == WR && open_req && !wr_fifo_full) begin
        wr_fifo_wr_d   = 1'b1;
        wr_fifo_data_d = wbs_dat_i;
        wr_fifo_mask_d = ~wbs_sel_i;
        ack_d          = 1'b1;
        next_addr_d    = next_addr + 22'd1;
      end
      RD_WAIT: rd_fifo_rd_d = (state_next == RD_POP);
      RD_CAP: if (state_next == RD) begin
        dat_d       = rd_fifo_data;
        ack_d       = 1'b1;
        next_addr_d = next_addr + 22'd1;
      end
      GAP: if (gap_cnt != '0) gap_cnt_d = gap_cnt - GW'(1);
      default: ;
    endcase

    if (state != GAP && state_next == GAP) begin
      write_en_d = 1'b0;
      read_en_d  = 1'b0;
      gap_cnt_d  = GAP_INIT;
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en      <= 1'b0;
      read_en       <= 1'b0;
      address       <= '0;
      next_addr     <= '0;
      wr_fifo_wr    <= 1'b0;
      wr_fifo_data  <= '0;
      wr_fifo_mask  <= '0;
      rd_fifo_rd    <= 1'b0;
      rd_fifo_reset <= 1'b0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      gap_cnt       <= '0;
      idle_cnt      <= '0;
    end else begin
      write_en      <= write_en_d;
      read_en       <= read_en_d;
      address       <= address_d;
      next_addr     <= next_addr_d;
      wr_fifo_wr    <= wr_fifo_wr_d;
      wr_fifo_data  <= wr_fifo_data_d;
      wr_fifo_mask  <= wr_fifo_mask_d;
      rd_fifo_rd    <= rd_fifo_rd_d;
      rd_fifo_reset <= rd_fifo_reset_d;
      wbs_ack_o     <= ack_d;
      wbs_dat_o     <= dat_d;
      gap_cnt       <= gap_cnt_d;
      idle_cnt      <= idle_cnt_d;
    end
  end

endmodule
